// File: rtl/fpmul_tb_pkg.sv
// Shared definitions for the FP multiplier result checker: IEEE-754 single
// field layout, checker FSM states and the NaN classifier.
package fpmul_tb_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam int MAN_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_e;

  // NaN: exponent all ones with a nonzero mantissa (sign and payload ignored).
  function automatic logic is_nan(input logic [FP_W-1:0] v);
    return (&v[EXP_MSB:EXP_LSB]) & (|v[MAN_MSB:MAN_LSB]);
  endfunction

endpackage

// File: rtl/fpmul_delay_line.sv
// Fixed-depth shift register carrying {valid, expected} words alongside the
// DUT pipeline; flush clears every stage so in-flight expectations are dropped.
module fpmul_delay_line #(
  parameter int WIDTH   = 33,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_word,
  output logic [WIDTH-1:0] tap_word
);

  logic [WIDTH-1:0] stage_r [LATENCY];

  // Shift every stage each cycle; stage 0 always loads the incoming word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < LATENCY; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= in_word;
      for (int i = 1; i < LATENCY; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign tap_word = stage_r[LATENCY-1];

endmodule

// File: rtl/fpmul_result_checker.sv
// Latency-aligned checker: delays each golden product by LATENCY cycles,
// compares it with the DUT output, counts results and records the first miss.
module fpmul_result_checker
  import fpmul_tb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LATENCY     = 4,
  parameter int CNT_W       = 16,
  parameter int NAN_EQUIV   = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] EXP,
  input  logic [WIDTH-1:0] DUT_Z,
  output logic             BUSY,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             ERR,
  output logic [CNT_W-1:0] FIRST_BAD_IDX,
  output logic [WIDTH-1:0] FIRST_BAD_EXP,
  output logic [WIDTH-1:0] FIRST_BAD_GOT
);

  localparam int               PW      = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             NAN_EQ  = (NAN_EQUIV != 0);
  localparam logic             STOP_EN = (STOP_ON_ERR != 0);

  chk_state_e       state_r, state_next_s;
  logic [PW-1:0]    pend_r, pend_next_s;
  logic             busy_r;
  logic [CNT_W-1:0] pass_r, fail_r, ord_r, bad_idx_r;
  logic             err_r;
  logic [WIDTH-1:0] bad_exp_r, bad_got_r;

  logic             en_eff_s, tap_valid_s, halted_s, check_s;
  logic             nan_match_s, match_s, pass_hit_s, fail_hit_s;
  logic [WIDTH:0]   tap_word_s;
  logic [WIDTH-1:0] tap_exp_s;

  // EN during a clear cycle must not enter the delay line.
  assign en_eff_s = EN & ~CLR;

  fpmul_delay_line #(
    .WIDTH  (WIDTH + 1),
    .LATENCY(LATENCY)
  ) u_delay_line (
    .clk     (CLK),
    .rst     (RST),
    .flush   (CLR),
    .in_word ({en_eff_s, EXP}),
    .tap_word(tap_word_s)
  );

  assign tap_valid_s = tap_word_s[WIDTH];
  assign tap_exp_s   = tap_word_s[WIDTH-1:0];
  assign halted_s    = (state_r == HALT);
  assign check_s     = tap_valid_s & ~halted_s;

  // NaN equivalence only applies when enabled; otherwise bitwise equality rules.
  always_comb begin
    nan_match_s = 1'b0;
    if (NAN_EQ) begin
      nan_match_s = is_nan(32'(tap_exp_s)) & is_nan(32'(DUT_Z));
    end else begin
      nan_match_s = 1'b0;
    end
  end

  assign match_s     = (tap_exp_s == DUT_Z) | nan_match_s;
  assign pass_hit_s  = check_s & match_s;
  assign fail_hit_s  = check_s & ~match_s;
  assign pend_next_s = pend_r + PW'(en_eff_s) - PW'(tap_valid_s);

  // Next-state logic; a mismatch with stop enabled wins over draining to idle.
  always_comb begin
    state_next_s = state_r;
    if (CLR) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (en_eff_s) state_next_s = RUN;
          else          state_next_s = IDLE;
        end
        RUN: begin
          if (fail_hit_s && STOP_EN)                  state_next_s = HALT;
          else if (pend_next_s == {PW{1'b0}} && !en_eff_s) state_next_s = IDLE;
          else                                        state_next_s = RUN;
        end
        HALT:    state_next_s = HALT;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State register, pending count and registered BUSY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      pend_r  <= {PW{1'b0}};
      busy_r  <= 1'b0;
    end else if (CLR) begin
      state_r <= IDLE;
      pend_r  <= {PW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
      busy_r  <= (pend_next_s != {PW{1'b0}});
    end
  end

  // Saturating counters and first-mismatch capture; saturation never blocks capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pass_r    <= {CNT_W{1'b0}};
      fail_r    <= {CNT_W{1'b0}};
      ord_r     <= {CNT_W{1'b0}};
      err_r     <= 1'b0;
      bad_idx_r <= {CNT_W{1'b0}};
      bad_exp_r <= {WIDTH{1'b0}};
      bad_got_r <= {WIDTH{1'b0}};
    end else if (CLR) begin
      pass_r    <= {CNT_W{1'b0}};
      fail_r    <= {CNT_W{1'b0}};
      ord_r     <= {CNT_W{1'b0}};
      err_r     <= 1'b0;
      bad_idx_r <= {CNT_W{1'b0}};
      bad_exp_r <= {WIDTH{1'b0}};
      bad_got_r <= {WIDTH{1'b0}};
    end else begin
      if (check_s && ord_r != CNT_MAX)     ord_r  <= ord_r + 1'b1;
      if (pass_hit_s && pass_r != CNT_MAX) pass_r <= pass_r + 1'b1;
      if (fail_hit_s && fail_r != CNT_MAX) fail_r <= fail_r + 1'b1;
      if (fail_hit_s && !err_r) begin
        err_r     <= 1'b1;
        bad_idx_r <= ord_r;
        bad_exp_r <= tap_exp_s;
        bad_got_r <= DUT_Z;
      end
    end
  end

  assign BUSY          = busy_r;
  assign PASS_CNT      = pass_r;
  assign FAIL_CNT      = fail_r;
  assign ERR           = err_r;
  assign FIRST_BAD_IDX = bad_idx_r;
  assign FIRST_BAD_EXP = bad_exp_r;
  assign FIRST_BAD_GOT = bad_got_r;

endmodule

// File: tb/tb_fpmul_result_checker.sv
// Bench for fpmul_result_checker: four configurations share one stimulus
// stream and are checked against a queue-based reference model every cycle.
module tb_fpmul_result_checker;
  import fpmul_tb_pkg::*;

  localparam int L = 4;

  logic        CLK, RST, CLR, EN;
  logic [31:0] EXP, DUT_Z;

  logic        busy_o [4];
  logic        err_o  [4];
  logic [15:0] pass_o [4], fail_o [4], idx_o [4];
  logic [31:0] bexp_o [4], bgot_o [4];
  logic [3:0]  pass_d, fail_d, idx_d;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Configuration table: a=default, b=no NaN equiv, c=stop on error, d=4-bit counters
  bit          nan_eq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          stop   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int unsigned cmax   [4] = '{65535, 65535, 65535, 15};

  typedef struct {
    int unsigned pass, fail, ord, idx;
    bit          err, halted;
    logic [31:0] bexp, bgot;
  } mdl_t;
  mdl_t m [4];

  typedef struct {
    logic [31:0] exp;
    int          at_cyc;
  } ent_t;
  ent_t q [$];

  typedef struct {
    logic [31:0] exp;
    logic [31:0] got;
    bit          pass_nan1;
    bit          pass_nan0;
  } nan_vec_t;

  logic [31:0] s_exp [32];
  logic [31:0] s_got [32];

  fpmul_result_checker #(.NAN_EQUIV(1)) u_a (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .EXP(EXP), .DUT_Z(DUT_Z),
    .BUSY(busy_o[0]), .PASS_CNT(pass_o[0]), .FAIL_CNT(fail_o[0]), .ERR(err_o[0]),
    .FIRST_BAD_IDX(idx_o[0]), .FIRST_BAD_EXP(bexp_o[0]), .FIRST_BAD_GOT(bgot_o[0]));

  fpmul_result_checker #(.NAN_EQUIV(0)) u_b (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .EXP(EXP), .DUT_Z(DUT_Z),
    .BUSY(busy_o[1]), .PASS_CNT(pass_o[1]), .FAIL_CNT(fail_o[1]), .ERR(err_o[1]),
    .FIRST_BAD_IDX(idx_o[1]), .FIRST_BAD_EXP(bexp_o[1]), .FIRST_BAD_GOT(bgot_o[1]));

  fpmul_result_checker #(.STOP_ON_ERR(1)) u_c (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .EXP(EXP), .DUT_Z(DUT_Z),
    .BUSY(busy_o[2]), .PASS_CNT(pass_o[2]), .FAIL_CNT(fail_o[2]), .ERR(err_o[2]),
    .FIRST_BAD_IDX(idx_o[2]), .FIRST_BAD_EXP(bexp_o[2]), .FIRST_BAD_GOT(bgot_o[2]));

  fpmul_result_checker #(.CNT_W(4)) u_d (
    .CLK(CLK), .RST(RST), .CLR(CLR), .EN(EN), .EXP(EXP), .DUT_Z(DUT_Z),
    .BUSY(busy_o[3]), .PASS_CNT(pass_d), .FAIL_CNT(fail_d), .ERR(err_o[3]),
    .FIRST_BAD_IDX(idx_d), .FIRST_BAD_EXP(bexp_o[3]), .FIRST_BAD_GOT(bgot_o[3]));

  assign pass_o[3] = {12'h000, pass_d};
  assign fail_o[3] = {12'h000, fail_d};
  assign idx_o[3]  = {12'h000, idx_d};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at t=%0t", name, act, want, $time);
    end
  endtask

  function automatic bit m_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'h0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i] = '{0, 0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0};
    q.delete();
  endtask

  // Reference model: one posedge; pops the expectation whose latency has elapsed.
  task automatic model_step(input bit en, input logic [31:0] exp, input logic [31:0] z, input bit clr);
    ent_t e;
    bit   match;
    cyc++;
    if (RST || clr) begin
      model_reset();
    end else begin
      if (q.size() != 0 && q[0].at_cyc + L == cyc) begin
        e = q.pop_front();
        for (int i = 0; i < 4; i++) begin
          if (!m[i].halted) begin
            match = (e.exp === z) || (nan_eq[i] && m_nan(e.exp) && m_nan(z));
            if (match) begin
              if (m[i].pass < cmax[i]) m[i].pass++;
            end else begin
              if (m[i].fail < cmax[i]) m[i].fail++;
              if (!m[i].err) begin
                m[i].err = 1'b1; m[i].idx = m[i].ord;
                m[i].bexp = e.exp; m[i].bgot = z;
                m[i].halted = stop[i];
              end
            end
            if (m[i].ord < cmax[i]) m[i].ord++;
          end
        end
      end
      if (en) q.push_back('{exp, cyc});
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy%0d", i), 64'(busy_o[i]), 64'(q.size() != 0));
      chk($sformatf("pass%0d", i), 64'(pass_o[i]), 64'(m[i].pass));
      chk($sformatf("fail%0d", i), 64'(fail_o[i]), 64'(m[i].fail));
      chk($sformatf("err%0d", i),  64'(err_o[i]),  64'(m[i].err));
      chk($sformatf("idx%0d", i),  64'(idx_o[i]),  64'(m[i].idx));
      chk($sformatf("bexp%0d", i), 64'(bexp_o[i]), 64'(m[i].bexp));
      chk($sformatf("bgot%0d", i), 64'(bgot_o[i]), 64'(m[i].bgot));
    end
  endtask

  task automatic cycle(input bit en, input logic [31:0] exp, input logic [31:0] z, input bit clr);
    EN = en; EXP = exp; DUT_Z = z; CLR = clr;
    @(posedge CLK);
    #1;
    model_step(en, exp, z, clr);
    check_all();
  endtask

  // Drives n pairs back-to-back; DUT_Z replays s_got L cycles later.
  task automatic run_stream(input int n, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      logic [31:0] z;
      logic [31:0] e;
      z = (k >= L && k - L < n) ? s_got[k-L] : 32'h0000_0000;
      e = (k < n) ? s_exp[k] : 32'h0000_0000;
      cycle(k < n, e, z, 1'b0);
    end
  endtask

  task automatic fill_pass(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      s_exp[k] = base + 32'(k * 3);
      s_got[k] = s_exp[k];
    end
  endtask

  nan_vec_t nvec [5];
  int unsigned pa0, pb0;

  initial begin
    nvec[0] = '{32'h7FC0_0000, 32'hFFC0_0001, 1'b1, 1'b0};
    nvec[1] = '{32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    nvec[2] = '{32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 1'b1};
    nvec[3] = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 1'b0};
    nvec[4] = '{32'hFF80_0001, 32'h7F80_0001, 1'b1, 1'b0};

    RST = 1'b1; CLR = 1'b0; EN = 1'b0; EXP = 32'h0; DUT_Z = 32'h0;
    model_reset();
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    RST = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 1'b0);

    // Pass stream
    fill_pass(10, 32'h3F80_0000);
    run_stream(10, 10 + L);
    chk("stream_pass", 64'(pass_o[0]), 64'd10);
    chk("stream_fail", 64'(fail_o[0]), 64'd0);
    chk("stream_busy", 64'(busy_o[0]), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Single mismatch at check 5, second mismatch at check 7
    for (int k = 0; k < 9; k++) begin
      s_exp[k] = (k == 5) ? 32'h3F80_0000 : 32'h4000_0000 + 32'(k);
      s_got[k] = s_exp[k];
    end
    s_got[5] = 32'h3F80_0001;
    s_got[7] = 32'hDEAD_BEEF;
    run_stream(9, 9 + L);
    chk("mis_err",  64'(err_o[0]),  64'd1);
    chk("mis_idx",  64'(idx_o[0]),  64'd5);
    chk("mis_bexp", 64'(bexp_o[0]), 64'h3F80_0000);
    chk("mis_bgot", 64'(bgot_o[0]), 64'h3F80_0001);
    chk("mis_fail", 64'(fail_o[0]), 64'd2);
    chk("mis_c_pass", 64'(pass_o[2]), 64'd5);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // NaN equivalence table
    for (int v = 0; v < 5; v++) begin
      pa0 = 32'(pass_o[0]); pb0 = 32'(pass_o[1]);
      s_exp[0] = nvec[v].exp; s_got[0] = nvec[v].got;
      run_stream(1, 1 + L);
      chk($sformatf("nan%0d_eq1", v), 64'(32'(pass_o[0]) - pa0), 64'(nvec[v].pass_nan1));
      chk($sformatf("nan%0d_eq0", v), 64'(32'(pass_o[1]) - pb0), 64'(nvec[v].pass_nan0));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Stop on error: mismatch at check 2, EN keeps coming
    fill_pass(6, 32'h4100_0000);
    s_got[2] = 32'h0000_0001;
    run_stream(6, 6 + L);
    chk("halt_state", 64'(u_c.state_r), 64'(HALT));
    chk("halt_pass",  64'(pass_o[2]), 64'd2);
    chk("halt_fail",  64'(fail_o[2]), 64'd1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);
    chk("halt_clr_state", 64'(u_c.state_r), 64'(IDLE));
    chk("halt_clr_err",   64'(err_o[2]), 64'd0);

    // Saturation on 4-bit counters, then a mismatch after saturation
    fill_pass(21, 32'h4200_0000);
    s_got[20] = 32'h0BAD_0BAD;
    run_stream(21, 21 + L);
    chk("sat_d_pass", 64'(pass_o[3]), 64'd15);
    chk("sat_d_err",  64'(err_o[3]),  64'd1);
    chk("sat_d_idx",  64'(idx_o[3]),  64'd15);
    chk("sat_a_pass", 64'(pass_o[0]), 64'd20);
    cycle(1'b0, 32'h0, 32'h0, 1'b1);

    // Clear with entries in flight and EN high in the clear cycle
    cycle(1'b1, 32'h1111_1111, 32'h0, 1'b0);
    cycle(1'b1, 32'h2222_2222, 32'h0, 1'b0);
    cycle(1'b1, 32'h3333_3333, 32'h0, 1'b0);
    cycle(1'b1, 32'h4444_4444, 32'h0, 1'b1);
    chk("clr_busy", 64'(busy_o[0]), 64'd0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 32'h5555_5555, 1'b0);
    chk("clr_nocheck", 64'(pass_o[0]) + 64'(fail_o[0]), 64'd0);

    // Asynchronous reset mid-stream, then a fresh aligned stream
    fill_pass(5, 32'h4300_0000);
    s_got[0] = 32'h0000_00FF;
    run_stream(5, 6);
    chk("pre_rst_err", 64'(err_o[0]), 64'd1);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_err",  64'(err_o[0]),  64'd0);
    chk("rst_busy", 64'(busy_o[0]), 64'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0);
    RST = 1'b0;
    fill_pass(3, 32'h4400_0000);
    run_stream(3, 3 + L);
    chk("post_rst_pass", 64'(pass_o[0]), 64'd3);
    chk("post_rst_fail", 64'(fail_o[0]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
